// File: rtl/rstatus_if.sv
// rstatus_if: bundles the execute-stage, multdiv and r30 writeback signals of rstatus_unit.
//   x_*        execute-stage instruction info (valid/stall/flush/opcode/aluop/overflow)
//   md_*       multdiv launch/completion handshake, md_busy reports an outstanding op
//   clr_sticky clears the debug sticky code and exception counter
//   rstatus_*  r30 write port; stall_req asks upstream to hold the pipeline
//   sticky_status / exc_count  debug observation
interface rstatus_if #(
  parameter int unsigned CODE_W = 32,
  parameter int unsigned CNT_W  = 8
) ();
  logic              x_valid;
  logic              x_stall;
  logic              x_flush;
  logic [4:0]        x_opcode;
  logic [4:0]        x_aluop;
  logic              x_ovf;
  logic              md_start;
  logic              md_ready;
  logic              md_exc;
  logic              clr_sticky;
  logic              rstatus_we;
  logic [CODE_W-1:0] rstatus_val;
  logic              stall_req;
  logic              md_busy;
  logic [CODE_W-1:0] sticky_status;
  logic [CNT_W-1:0]  exc_count;

  // Driver side (pipeline / testbench)
  modport master (
    output x_valid, x_stall, x_flush, x_opcode, x_aluop, x_ovf,
    output md_start, md_ready, md_exc, clr_sticky,
    input  rstatus_we, rstatus_val, stall_req, md_busy, sticky_status, exc_count
  );

  // rstatus_unit side
  modport slave (
    input  x_valid, x_stall, x_flush, x_opcode, x_aluop, x_ovf,
    input  md_start, md_ready, md_exc, clr_sticky,
    output rstatus_we, rstatus_val, stall_req, md_busy, sticky_status, exc_count
  );
endinterface

// File: rtl/rstatus_unit.sv
// rstatus_unit: detects ALU overflow (add/addi/sub) and multdiv exceptions (mul/div), queues
// their status codes and issues at most one r30 write per cycle.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    rstatus_if.slave: execute/multdiv inputs, r30 write port, stall request, debug state
module rstatus_unit #(
  parameter int unsigned       CODE_W    = 32,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       CNT_W     = 8,
  parameter logic [CODE_W-1:0] CODE_ADDI = CODE_W'(1),
  parameter logic [CODE_W-1:0] CODE_ADD  = CODE_W'(2),
  parameter logic [CODE_W-1:0] CODE_SUB  = CODE_W'(3),
  parameter logic [CODE_W-1:0] CODE_MUL  = CODE_W'(4),
  parameter logic [CODE_W-1:0] CODE_DIV  = CODE_W'(5)
) (
  input logic     clock,
  input logic     reset,
  rstatus_if.slave bus
);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] DepthCnt = (AddrW+1)'(DEPTH);

  // Decode
  logic w_rtype, w_is_add, w_is_sub, w_is_mul, w_is_div, w_is_addi, w_x_go;
  assign w_rtype   = (bus.x_opcode == 5'b00000);
  assign w_is_add  = w_rtype & (bus.x_aluop == 5'b00000);
  assign w_is_sub  = w_rtype & (bus.x_aluop == 5'b00001);
  assign w_is_mul  = w_rtype & (bus.x_aluop == 5'b00110);
  assign w_is_div  = w_rtype & (bus.x_aluop == 5'b00111);
  assign w_is_addi = (bus.x_opcode == 5'b00101);
  assign w_x_go    = bus.x_valid & ~bus.x_stall & ~bus.x_flush;

  logic              w_alu_ev;
  logic [CODE_W-1:0] w_alu_code;
  assign w_alu_ev = w_x_go & bus.x_ovf & (w_is_add | w_is_addi | w_is_sub);

  always_comb begin
    w_alu_code = CODE_SUB;
    if (w_is_addi)     w_alu_code = CODE_ADDI;
    else if (w_is_add) w_alu_code = CODE_ADD;
  end

  // Multdiv tracking
  logic              r_md_busy;
  logic [CODE_W-1:0] r_md_code;
  logic              w_md_done, w_md_push, w_md_launch;
  assign w_md_done   = bus.md_ready & r_md_busy;
  assign w_md_push   = w_md_done & bus.md_exc;
  // A completing op frees the unit in the same cycle, so back-to-back launch is allowed
  assign w_md_launch = bus.md_start & (~r_md_busy | w_md_done) & w_x_go & (w_is_mul | w_is_div);

  // Queue
  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [AddrW-1:0]  r_wptr, r_rptr;
  logic [AddrW:0]    r_count;
  logic              r_we;
  logic [CODE_W-1:0] r_val;
  logic [CODE_W-1:0] r_sticky;
  logic [CNT_W-1:0]  r_exc_cnt;

  logic              w_pop;
  logic [AddrW:0]    w_avail, w_net;
  logic              w_s0_v, w_s1_v, w_acc0, w_acc1;
  logic [CODE_W-1:0] w_s0_code, w_s1_code;

  assign w_pop   = (r_count != '0);
  // Slot freed by this cycle's pop is reusable by this cycle's pushes
  assign w_avail = DepthCnt - r_count + (AddrW+1)'(w_pop);
  assign w_net   = r_count - (AddrW+1)'(w_pop);

  // Multdiv code goes first: it belongs to the older instruction
  always_comb begin
    w_s0_v    = 1'b0;
    w_s0_code = w_alu_code;
    w_s1_v    = 1'b0;
    w_s1_code = w_alu_code;
    if (w_md_push) begin
      w_s0_v    = 1'b1;
      w_s0_code = r_md_code;
      w_s1_v    = w_alu_ev;
    end else begin
      w_s0_v = w_alu_ev;
    end
  end

  // Pushes beyond the free space are dropped rather than overwriting
  assign w_acc0 = w_s0_v & (w_avail != '0);
  assign w_acc1 = w_s1_v & (w_avail >= (AddrW+1)'(2));

  always_ff @(posedge clock) begin
    if (w_acc0) r_mem[r_wptr] <= w_s0_code;
    if (w_acc1) r_mem[r_wptr + AddrW'(1)] <= w_s1_code;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_we      <= 1'b0;
      r_val     <= '0;
      r_md_busy <= 1'b0;
      r_md_code <= '0;
      r_sticky  <= '0;
      r_exc_cnt <= '0;
    end else begin
      r_wptr  <= r_wptr + AddrW'(w_acc0) + AddrW'(w_acc1);
      r_rptr  <= r_rptr + AddrW'(w_pop);
      r_count <= r_count + (AddrW+1)'(w_acc0) + (AddrW+1)'(w_acc1) - (AddrW+1)'(w_pop);
      r_we    <= w_pop;
      r_val   <= w_pop ? r_mem[r_rptr] : '0;

      if (w_md_launch) begin
        r_md_busy <= 1'b1;
        r_md_code <= w_is_mul ? CODE_MUL : CODE_DIV;
      end else if (w_md_done) begin
        r_md_busy <= 1'b0;
      end

      if (bus.clr_sticky) begin
        r_sticky  <= '0;
        r_exc_cnt <= '0;
      end else if (r_we) begin
        r_sticky <= r_val;
        if (r_exc_cnt != '1) r_exc_cnt <= r_exc_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.rstatus_we    = r_we;
  assign bus.rstatus_val   = r_val;
  assign bus.stall_req     = (w_net > (AddrW+1)'(DEPTH - 2));
  assign bus.md_busy       = r_md_busy;
  assign bus.sticky_status = r_sticky;
  assign bus.exc_count     = r_exc_cnt;
endmodule

// File: tb/tb_rstatus_unit.sv
// tb_rstatus_unit: directed self-checking bench for rstatus_unit (DEPTH=4 main instance, plus a
// DEPTH=2 instance sharing the same inputs to exercise stall_req).
module tb_rstatus_unit;
  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] got[$];
  logic [31:0] exp_seq[7];

  rstatus_if #(.CODE_W(32), .CNT_W(8)) bus ();
  rstatus_if #(.CODE_W(32), .CNT_W(8)) bus2 ();

  assign bus2.x_valid    = bus.x_valid;
  assign bus2.x_stall    = bus.x_stall;
  assign bus2.x_flush    = bus.x_flush;
  assign bus2.x_opcode   = bus.x_opcode;
  assign bus2.x_aluop    = bus.x_aluop;
  assign bus2.x_ovf      = bus.x_ovf;
  assign bus2.md_start   = bus.md_start;
  assign bus2.md_ready   = bus.md_ready;
  assign bus2.md_exc     = bus.md_exc;
  assign bus2.clr_sticky = bus.clr_sticky;

  rstatus_unit #(.DEPTH(4)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  rstatus_unit #(.DEPTH(2)) u_dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; record every r30 write seen on the main instance
  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.rstatus_we) got.push_back(bus.rstatus_val);
  endtask

  task automatic idle();
    bus.x_valid    = 1'b0;
    bus.x_stall    = 1'b0;
    bus.x_flush    = 1'b0;
    bus.x_opcode   = 5'd0;
    bus.x_aluop    = 5'd0;
    bus.x_ovf      = 1'b0;
    bus.md_start   = 1'b0;
    bus.md_ready   = 1'b0;
    bus.md_exc     = 1'b0;
    bus.clr_sticky = 1'b0;
  endtask

  task automatic x_instr(input logic [4:0] op, input logic [4:0] aluop, input logic ovf);
    bus.x_valid  = 1'b1;
    bus.x_opcode = op;
    bus.x_aluop  = aluop;
    bus.x_ovf    = ovf;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_we", bus.rstatus_we, 0);
    chk("rst_val", bus.rstatus_val, 0);
    chk("rst_sticky", bus.sticky_status, 0);
    chk("rst_cnt", bus.exc_count, 0);
    chk("rst_stall", bus.stall_req, 0);
    chk("rst_busy", bus.md_busy, 0);
    got.delete();

    // add overflow: write of 2 one cycle after the push edge, sticky one cycle later
    x_instr(5'b00000, 5'b00000, 1'b1);
    tick();
    idle();
    chk("add_we_early", bus.rstatus_we, 0);
    tick();
    chk("add_we", bus.rstatus_we, 1);
    chk("add_val", bus.rstatus_val, 2);
    tick();
    chk("add_sticky", bus.sticky_status, 2);
    chk("add_cnt", bus.exc_count, 1);
    chk("add_we_after", bus.rstatus_we, 0);

    // addi squashed by flush, then held by stall, then accepted
    x_instr(5'b00101, 5'b00000, 1'b1);
    bus.x_flush = 1'b1;
    tick();
    idle();
    tick();
    tick();
    chk("addi_flush", got.size(), 1);
    x_instr(5'b00101, 5'b00000, 1'b1);
    bus.x_stall = 1'b1;
    tick();
    idle();
    tick();
    tick();
    chk("addi_stall", got.size(), 1);
    chk("addi_stall_cnt", bus.exc_count, 1);
    x_instr(5'b00101, 5'b00000, 1'b1);
    tick();
    idle();
    tick();
    tick();
    chk("addi_ok_n", got.size(), 2);
    chk("addi_ok_val", got[1], 1);

    // md_start on a non-mul/div decode and md_ready while idle are both ignored
    got.delete();
    x_instr(5'b00000, 5'b00000, 1'b0);
    bus.md_start = 1'b1;
    tick();
    idle();
    chk("md_nodec_busy", bus.md_busy, 0);
    bus.md_ready = 1'b1;
    bus.md_exc   = 1'b1;
    tick();
    idle();
    tick();
    tick();
    chk("md_idle_ready", got.size(), 0);

    // div with exception
    x_instr(5'b00000, 5'b00111, 1'b0);
    bus.md_start = 1'b1;
    tick();
    idle();
    chk("div_busy", bus.md_busy, 1);
    repeat (4) tick();
    bus.md_ready = 1'b1;
    bus.md_exc   = 1'b1;
    tick();
    idle();
    chk("div_busy_fall", bus.md_busy, 0);
    tick();
    tick();
    chk("div_exc_n", got.size(), 1);
    chk("div_exc_val", got[0], 5);

    // div without exception
    got.delete();
    x_instr(5'b00000, 5'b00111, 1'b0);
    bus.md_start = 1'b1;
    tick();
    idle();
    repeat (4) tick();
    bus.md_ready = 1'b1;
    tick();
    idle();
    chk("div_noexc_busy", bus.md_busy, 0);
    tick();
    tick();
    tick();
    chk("div_noexc_n", got.size(), 0);

    // A second md_start while busy must not replace the captured mul code
    x_instr(5'b00000, 5'b00110, 1'b0);
    bus.md_start = 1'b1;
    tick();
    idle();
    x_instr(5'b00000, 5'b00111, 1'b0);
    bus.md_start = 1'b1;
    tick();
    idle();
    bus.md_ready = 1'b1;
    bus.md_exc   = 1'b1;
    tick();
    idle();
    tick();
    tick();
    chk("md_busy_ign_n", got.size(), 1);
    chk("md_busy_ign_val", got[0], 4);

    // mul completion together with sub overflow: 4 then 3
    got.delete();
    x_instr(5'b00000, 5'b00110, 1'b0);
    bus.md_start = 1'b1;
    tick();
    idle();
    x_instr(5'b00000, 5'b00001, 1'b1);
    bus.md_ready = 1'b1;
    bus.md_exc   = 1'b1;
    tick();
    idle();
    chk("dual_stall_d4", bus.stall_req, 0);
    chk("dual_stall_d2", bus2.stall_req, 1);
    tick();
    chk("dual_we0", bus.rstatus_we, 1);
    chk("dual_val0", bus.rstatus_val, 4);
    tick();
    chk("dual_we1", bus.rstatus_we, 1);
    chk("dual_val1", bus.rstatus_val, 3);
    tick();
    chk("dual_we2", bus.rstatus_we, 0);
    chk("dual_d2_stall_off", bus2.stall_req, 0);

    // Sustained sub overflow with a mul exception landing in the middle
    got.delete();
    x_instr(5'b00000, 5'b00110, 1'b0);
    bus.md_start = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      x_instr(5'b00000, 5'b00001, 1'b1);
      if (i == 1) begin
        bus.md_ready = 1'b1;
        bus.md_exc   = 1'b1;
      end
      tick();
      idle();
      chk("sust_stall", bus.stall_req, 0);
    end
    repeat (4) tick();
    exp_seq = '{32'd3, 32'd4, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
    chk("sust_n", got.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < got.size()) chk("sust_order", got[i], exp_seq[i]);
    end

    // clr_sticky beats a same-cycle sticky update
    chk("pre_clr_sticky", bus.sticky_status, 3);
    x_instr(5'b00000, 5'b00001, 1'b1);
    tick();
    idle();
    tick();
    chk("clr_we", bus.rstatus_we, 1);
    bus.clr_sticky = 1'b1;
    tick();
    bus.clr_sticky = 1'b0;
    chk("clr_sticky", bus.sticky_status, 0);
    chk("clr_cnt", bus.exc_count, 0);

    // Reset with queued codes and an outstanding div
    x_instr(5'b00000, 5'b00110, 1'b0);
    bus.md_start = 1'b1;
    tick();
    idle();
    x_instr(5'b00000, 5'b00001, 1'b1);
    bus.md_ready = 1'b1;
    bus.md_exc   = 1'b1;
    tick();
    idle();
    x_instr(5'b00000, 5'b00111, 1'b0);
    bus.md_start = 1'b1;
    tick();
    idle();
    chk("prerst_busy", bus.md_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_we", bus.rstatus_we, 0);
    chk("mrst_val", bus.rstatus_val, 0);
    chk("mrst_busy", bus.md_busy, 0);
    chk("mrst_stall", bus.stall_req, 0);
    chk("mrst_sticky", bus.sticky_status, 0);
    chk("mrst_cnt", bus.exc_count, 0);
    got.delete();
    bus.md_ready = 1'b1;
    bus.md_exc   = 1'b1;
    tick();
    idle();
    repeat (3) tick();
    chk("mrst_ready_ign", got.size(), 0);
    chk("mrst_busy_after", bus.md_busy, 0);

    // 300 writes saturate the 8-bit counter
    x_instr(5'b00000, 5'b00001, 1'b1);
    repeat (300) tick();
    idle();
    repeat (3) tick();
    chk("sat_n", got.size(), 300);
    chk("sat_cnt", bus.exc_count, 255);
    chk("sat_sticky", bus.sticky_status, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
